gpc223_4_acc: RTL and testbench
===============================

# gpc223_4_acc

Streaming accumulator downstream of the `gpc223_4` generalized parallel counter. Each accepted beat carries one 4-bit `gpc223_4` result (`dst`, value 0..15). The block sums beats over a frame delimited by `in_last`, saturating at the accumulator width. It presents the frame sum, beat count and an overflow flag on a valid/ready output register. It is the reduction stage that turns per-cycle GPC counts into per-frame totals.

## Interface
Parameters:
- `ACC_W`, default 8: accumulator and sum width in bits. Must be ≥ 4.
- `CNT_W`, default 8: beat-counter width in bits.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: input beat valid.
- `in_ready`, output, 1: block can accept a beat.
- `in_dst`, input, 4: `gpc223_4` `dst` value (unsigned, 0..15).
- `in_last`, input, 1: this beat closes the frame.
- `out_valid`, output, 1: result register holds a frame result.
- `out_ready`, input, 1: consumer takes the result.
- `out_sum`, output, `ACC_W`: saturated frame sum.
- `out_count`, output, `CNT_W`: beats in frame, saturating.
- `out_ovf`, output, 1: sum or count saturated during the frame.

## Operation
- Accept: `acc_fire = in_valid && in_ready`.
- Output transfer: `out_fire = out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational and gives single-register pass-through with no bubble.
- The frame state is `acc` (`ACC_W` bits), `cnt` (`CNT_W` bits) and `ovf` (1 bit). All are zero between frames.
- On `acc_fire` without `in_last`:
  - `acc <= sat(acc + in_dst)`.
  - `cnt <= sat(cnt + 1)`.
  - `ovf` is set if either addition saturates. `ovf` is sticky.
- On `acc_fire` with `in_last`:
  - `out_sum <= sat(acc + in_dst)`.
  - `out_count <= sat(cnt + 1)`.
  - `out_ovf <= ovf | (saturation on this beat)`.
  - `out_valid <= 1`.
  - `acc`, `cnt` and `ovf` clear to 0.
- Saturation rules:
  - Compute each sum at `ACC_W+1` bits.
  - If bit `ACC_W` is set, clamp the result to 2^ACC_W−1.
  - The same rule applies to `cnt` at `CNT_W`.
- Output FSM, two states:
  - EMPTY (`out_valid=0`): go to FULL on a last-beat accept.
  - FULL (`out_valid=1`):
    - `out_fire` without a last-beat accept: go to EMPTY.
    - `out_fire` with a last-beat accept in the same cycle: stay in FULL and load the new result.
    - Otherwise hold. `out_sum`, `out_count` and `out_ovf` are stable while `out_valid && !out_ready`.
- While in FULL and stalled, `in_ready=0`. The frame accumulator does not advance.
- A single-beat frame (`in_last` on the first beat) is legal: `out_count = 1`.
- A zero-valued `in_dst` still counts as a beat.

## Timing
- Reset values: `out_valid=0`, `out_sum=0`, `out_count=0`, `out_ovf=0`, `acc=0`, `cnt=0`, `ovf=0`. `in_ready=1` after reset because it follows from `out_valid=0`.
- Reset mid-frame discards the partial frame and any pending output. The first accepted beat after reset release starts a new frame.
- Latency: a last beat accepted at edge k gives `out_valid=1` with the result visible immediately after edge k.
- Throughput: one beat per cycle, including back-to-back single-beat frames, while `out_ready=1`.
- There is no combinational path from `in_*` to `out_*`. The only combinational path is `out_ready` → `in_ready`.

## Test plan
- Reset, then one beat `in_dst=15`, `in_last=1`, with `out_ready=1` → next cycle `out_valid=1`, `out_sum=15`, `out_count=1`, `out_ovf=0`.
- Frame of beats 3, 7, 0, 12 (last on the fourth) → `out_sum=22`, `out_count=4`, `out_ovf=0`.
- With `ACC_W=8`:
  - 17 beats of 15 → `out_sum=255`, `out_ovf=0`.
  - 18 beats of 15 → `out_sum=255`, `out_ovf=1`.
  - The next frame of a single beat of 1 → `out_sum=1`, `out_ovf=0` (sticky flag cleared).
- Hold `out_ready=0` after a completed frame, drive `in_valid=1` → `in_ready=0` and the outputs stay stable for 5 cycles. Then raise `out_ready` → the next frame is accepted the same cycle.
- Back-to-back single-beat frames of 1..16 with `out_ready=1` → 16 consecutive `out_valid` cycles with `out_sum` = 1..15, then 0 (16 truncates to 4 bits), and `out_count=1` each.
- Assert `rst` after 3 beats of a frame, then send one last beat of 5 → `out_sum=5`, `out_count=1`. No output appears during reset.

Source files
------------

// File: rtl/gpc223_4_acc.sv
// Per-frame reduction of 4-bit gpc223_4 counts: saturating sum, beat count and overflow flag,
// presented through a single valid/ready output register with bubble-free pass-through.
module gpc223_4_acc #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_dst,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W-1:0] r_outSum;
  logic [CNT_W-1:0] r_outCount;
  logic             r_outOvf;

  logic             w_accFire;
  logic             w_outFire;
  logic             w_lastFire;
  logic [ACC_W:0]   w_accSum;
  logic [CNT_W:0]   w_cntSum;
  logic [ACC_W-1:0] w_accNext;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_satNow;

  assign out_valid  = (r_state == S_FULL);
  assign in_ready   = !out_valid || out_ready;
  assign w_accFire  = in_valid && in_ready;
  assign w_outFire  = out_valid && out_ready;
  assign w_lastFire = w_accFire && in_last;

  // Sums are formed one bit wider; the carry bit both clamps the value and flags overflow.
  assign w_accSum  = {1'b0, r_acc} + {{(ACC_W-3){1'b0}}, in_dst};
  assign w_cntSum  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_accNext = w_accSum[ACC_W] ? {ACC_W{1'b1}} : w_accSum[ACC_W-1:0];
  assign w_cntNext = w_cntSum[CNT_W] ? {CNT_W{1'b1}} : w_cntSum[CNT_W-1:0];
  assign w_satNow  = w_accSum[ACC_W] | w_cntSum[CNT_W];

  assign out_sum   = r_outSum;
  assign out_count = r_outCount;
  assign out_ovf   = r_outOvf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_outSum   <= '0;
      r_outCount <= '0;
      r_outOvf   <= 1'b0;
    end else begin
      if (w_lastFire) begin
        r_outSum   <= w_accNext;
        r_outCount <= w_cntNext;
        r_outOvf   <= r_ovf | w_satNow;
        r_acc      <= '0;
        r_cnt      <= '0;
        r_ovf      <= 1'b0;
      end else if (w_accFire) begin
        r_acc <= w_accNext;
        r_cnt <= w_cntNext;
        r_ovf <= r_ovf | w_satNow;
      end

      // A last beat accepted while the old result drains reloads FULL in the same cycle.
      case (r_state)
        S_EMPTY: if (w_lastFire) r_state <= S_FULL;
        S_FULL:  if (w_outFire && !w_lastFire) r_state <= S_EMPTY;
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_gpc223_4_acc.sv
// Randomized and directed bench for gpc223_4_acc, checked against a per-frame arithmetic model.
module tb_gpc223_4_acc;

  localparam int ACC_W = 8;
  localparam int CNT_W = 8;
  localparam int ACC_MAX = (1 << ACC_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_dst;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int compared;
  int mismatched;

  // Reference model: the true (unclamped) frame total and beat count, clamped only on frame close.
  int               frameSum;
  int               frameCnt;
  logic [ACC_W-1:0] expSum;
  logic [CNT_W-1:0] expCnt;
  logic             expOvf;

  gpc223_4_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dst    (in_dst),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void modelBeat(input int d, input bit last);
    frameSum += d;
    frameCnt += 1;
    if (last) begin
      expSum   = ACC_W'((frameSum > ACC_MAX) ? ACC_MAX : frameSum);
      expCnt   = CNT_W'((frameCnt > CNT_MAX) ? CNT_MAX : frameCnt);
      expOvf   = (frameSum > ACC_MAX) || (frameCnt > CNT_MAX);
      frameSum = 0;
      frameCnt = 0;
    end
  endfunction

  // Drives one beat, waits (bounded) for acceptance, and returns 1ns after the accepting edge.
  task automatic sendBeat(input logic [3:0] d, input bit last);
    int waitCycles;
    in_valid = 1'b1;
    in_dst   = d;
    in_last  = last;
    #1;
    waitCycles = 0;
    while (!in_ready && waitCycles < 20) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout in_ready got %0b want 1", in_ready);
    end
    @(posedge clk);
    modelBeat(int'(d), last);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_dst    = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    frameSum  = 0;
    frameCnt  = 0;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got %0b want 0", out_valid); end
    compared++; if (out_sum !== '0) begin mismatched++; $display("[TB] FAIL reset_sum got %0d want 0", out_sum); end
    compared++; if (out_count !== '0) begin mismatched++; $display("[TB] FAIL reset_count got %0d want 0", out_count); end
    compared++; if (out_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ovf got %0b want 0", out_ovf); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready got %0b want 1", in_ready); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_beat();
    sendBeat(4'd15, 1'b1);
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_valid got %0b want 1", out_valid); end
    compared++; if (out_sum !== expSum) begin mismatched++; $display("[TB] FAIL single_sum got %0d want %0d", out_sum, expSum); end
    compared++; if (out_count !== expCnt) begin mismatched++; $display("[TB] FAIL single_count got %0d want %0d", out_count, expCnt); end
    compared++; if (out_ovf !== expOvf) begin mismatched++; $display("[TB] FAIL single_ovf got %0b want %0b", out_ovf, expOvf); end
  endtask

  task automatic test_frame();
    int beats [4] = '{3, 7, 0, 12};
    for (int i = 0; i < 4; i++) sendBeat(4'(beats[i]), i == 3);
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL frame_valid got %0b want 1", out_valid); end
    compared++; if (out_sum !== expSum) begin mismatched++; $display("[TB] FAIL frame_sum got %0d want %0d", out_sum, expSum); end
    compared++; if (out_count !== expCnt) begin mismatched++; $display("[TB] FAIL frame_count got %0d want %0d", out_count, expCnt); end
    compared++; if (out_ovf !== expOvf) begin mismatched++; $display("[TB] FAIL frame_ovf got %0b want %0b", out_ovf, expOvf); end
  endtask

  task automatic test_saturation();
    int lens [3] = '{17, 18, 1};
    int vals [3] = '{15, 15, 1};
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < lens[f]; b++) sendBeat(4'(vals[f]), b == lens[f] - 1);
      compared++; if (out_sum !== expSum) begin mismatched++; $display("[TB] FAIL sat_sum[%0d] got %0d want %0d", f, out_sum, expSum); end
      compared++; if (out_count !== expCnt) begin mismatched++; $display("[TB] FAIL sat_count[%0d] got %0d want %0d", f, out_count, expCnt); end
      compared++; if (out_ovf !== expOvf) begin mismatched++; $display("[TB] FAIL sat_ovf[%0d] got %0b want %0b", f, out_ovf, expOvf); end
    end
    // Beat counter clamping on a long frame of zero-valued beats.
    for (int b = 0; b < CNT_MAX + 5; b++) sendBeat(4'd0, b == CNT_MAX + 4);
    compared++; if (out_count !== expCnt) begin mismatched++; $display("[TB] FAIL cntsat_count got %0d want %0d", out_count, expCnt); end
    compared++; if (out_ovf !== expOvf) begin mismatched++; $display("[TB] FAIL cntsat_ovf got %0b want %0b", out_ovf, expOvf); end
    compared++; if (out_sum !== expSum) begin mismatched++; $display("[TB] FAIL cntsat_sum got %0d want %0d", out_sum, expSum); end
  endtask

  task automatic test_stall();
    logic [ACC_W-1:0] heldSum;
    logic [CNT_W-1:0] heldCnt;
    sendBeat(4'd5, 1'b0);
    sendBeat(4'd6, 1'b1);
    heldSum   = expSum;
    heldCnt   = expCnt;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_dst    = 4'd9;
    in_last   = 1'b1;
    #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_ready got %0b want 0", in_ready); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      compared++; if (out_valid !== 1'b1 || out_sum !== heldSum || out_count !== heldCnt || in_ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL stall_hold[%0d] got v=%0b s=%0d c=%0d r=%0b want v=1 s=%0d c=%0d r=0", c, out_valid, out_sum, out_count, in_ready, heldSum, heldCnt);
      end
    end
    out_ready = 1'b1;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL release_ready got %0b want 1", in_ready); end
    @(posedge clk);
    modelBeat(9, 1'b1);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    compared++; if (out_valid !== 1'b1 || out_sum !== expSum || out_count !== expCnt) begin
      mismatched++;
      $display("[TB] FAIL release_load got v=%0b s=%0d c=%0d want v=1 s=%0d c=%0d", out_valid, out_sum, out_count, expSum, expCnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 16; i++) begin
      sendBeat(4'(i), 1'b1);
      compared++; if (out_valid !== 1'b1 || out_sum !== ACC_W'(i % 16) || out_count !== CNT_W'(1)) begin
        mismatched++;
        $display("[TB] FAIL b2b[%0d] got v=%0b s=%0d c=%0d want v=1 s=%0d c=1", i, out_valid, out_sum, out_count, i % 16);
      end
    end
  endtask

  task automatic test_random();
    int len;
    int stall;
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 30);
      for (int b = 0; b < len; b++) sendBeat(4'($urandom_range(0, 15)), b == len - 1);
      compared++; if (out_valid !== 1'b1 || out_sum !== expSum || out_count !== expCnt || out_ovf !== expOvf) begin
        mismatched++;
        $display("[TB] FAIL rand[%0d] got s=%0d c=%0d o=%0b want s=%0d c=%0d o=%0b", f, out_sum, out_count, out_ovf, expSum, expCnt, expOvf);
      end
      stall = $urandom_range(0, 3);
      if (stall > 0) begin
        out_ready = 1'b0;
        repeat (stall) @(posedge clk);
        #1;
        compared++; if (out_valid !== 1'b1 || out_sum !== expSum) begin
          mismatched++;
          $display("[TB] FAIL rand_stall[%0d] got v=%0b s=%0d want v=1 s=%0d", f, out_valid, out_sum, expSum);
        end
        out_ready = 1'b1;
      end
    end
  endtask

  task automatic test_reset_midframe();
    for (int b = 0; b < 3; b++) sendBeat(4'd7, 1'b0);
    rst = 1'b1;
    frameSum = 0;
    frameCnt = 0;
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_async got %0b want 0", out_valid); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_valid[%0d] got %0b want 0", c, out_valid); end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    sendBeat(4'd5, 1'b1);
    compared++; if (out_valid !== 1'b1 || out_sum !== expSum || out_count !== expCnt || out_ovf !== expOvf) begin
      mismatched++;
      $display("[TB] FAIL midrst_frame got v=%0b s=%0d c=%0d o=%0b want v=1 s=%0d c=%0d o=%0b", out_valid, out_sum, out_count, out_ovf, expSum, expCnt, expOvf);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_single_beat();
    test_frame();
    test_saturation();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
